// File: rtl/decode_pipe_stage.sv
// decode_pipe_stage: RV32 decode with internal register file, ID/EX register, valid/ready handshake and load-use stall.
// Define DECODE_BYPASS_EN to forward same-cycle writeback data into captured and held operands.
module decode_controller (
  input  logic [31:0] instruction_i,
  output logic        alu_src_o,
  output logic        mem_write_o,
  output logic        wb_load_o,
  output logic        wb_reg_file_o,
  output logic        invalid_inst_o,
  output logic        m_type_inst_o,
  output logic [2:0]  mem_load_type_o,
  output logic [1:0]  mem_store_type_o
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  assign op = instruction_i[6:0];
  assign f3 = instruction_i[14:12];
  assign f7 = instruction_i[31:25];
  always_comb begin
    alu_src_o        = 1'b0;
    mem_write_o      = 1'b0;
    wb_load_o        = 1'b0;
    wb_reg_file_o    = 1'b0;
    invalid_inst_o   = 1'b0;
    m_type_inst_o    = 1'b0;
    mem_load_type_o  = 3'd0;
    mem_store_type_o = 2'd0;
    case (op)
      7'b0000011: begin
        alu_src_o       = 1'b1;
        wb_load_o       = 1'b1;
        wb_reg_file_o   = 1'b1;
        mem_load_type_o = f3;
        invalid_inst_o  = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
      end
      7'b0100011: begin
        alu_src_o        = 1'b1;
        mem_write_o      = 1'b1;
        mem_store_type_o = f3[1:0];
        invalid_inst_o   = f3 > 3'd2;
      end
      7'b1100011: invalid_inst_o = f3 == 3'd2 || f3 == 3'd3;
      7'b1100111: begin
        alu_src_o      = 1'b1;
        wb_reg_file_o  = 1'b1;
        invalid_inst_o = f3 != 3'd0;
      end
      7'b1101111, 7'b0110111, 7'b0010111: begin
        alu_src_o     = 1'b1;
        wb_reg_file_o = 1'b1;
      end
      7'b0010011: begin
        alu_src_o      = 1'b1;
        wb_reg_file_o  = 1'b1;
        invalid_inst_o = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'b0110011: begin
        wb_reg_file_o  = 1'b1;
        m_type_inst_o  = f7 == 7'h01;
        invalid_inst_o = !(f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0001111, 7'b1110011: ;
      default: invalid_inst_o = 1'b1;
    endcase
  end
endmodule

module decode_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            id_flush,
  input  logic            ex_ready,
  input  logic            reg_file_wr_en,
  input  logic [4:0]      reg_file_wr_addr,
  input  logic [XLEN-1:0] reg_file_wr_data,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] immediate,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic            alu_src,
  output logic            mem_write,
  output logic            wb_load,
  output logic            wb_reg_file,
  output logic            invalid_inst,
  output logic            m_type_inst,
  output logic [2:0]      mem_load_type,
  output logic [1:0]      mem_store_type
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_STORE = 7'b0100011, OP_OP = 7'b0110011;
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [31:0] ins;
  logic [6:0] opc_d, f7_d;
  logic [4:0] rd_d, rs1_d, rs2_d;
  logic [2:0] f3_d;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm_d, rf1, rf2, op1_d, op2_d;
  logic use_rd, use_rs1, use_rs2, bad_idx, wr_ok, hazard, advance, capture;
  logic c_alu_src, c_mem_write, c_wb_load, c_wb_reg_file, c_invalid, c_m_type;
  logic [2:0] c_ld;
  logic [1:0] c_st;
  assign ins   = instruction_in;
  assign opc_d = ins[6:0];
  assign rd_d  = ins[11:7];
  assign f3_d  = ins[14:12];
  assign rs1_d = ins[19:15];
  assign rs2_d = ins[24:20];
  assign f7_d  = ins[31:25];
  decode_controller u_ctrl (
    .instruction_i    (ins),
    .alu_src_o        (c_alu_src),
    .mem_write_o      (c_mem_write),
    .wb_load_o        (c_wb_load),
    .wb_reg_file_o    (c_wb_reg_file),
    .invalid_inst_o   (c_invalid),
    .m_type_inst_o    (c_m_type),
    .mem_load_type_o  (c_ld),
    .mem_store_type_o (c_st)
  );
  assign imm32 = opc_d == OP_STORE  ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                 opc_d == OP_JAL    ? {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
                 opc_d == OP_BRANCH ? {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
                 (opc_d == OP_LUI || opc_d == OP_AUIPC) ? {ins[31:12], 12'h000} :
                 {{20{ins[31]}}, ins[31:20]};
  assign imm_d = XLEN'($signed(imm32));
  assign use_rd  = !(opc_d == OP_STORE || opc_d == OP_BRANCH);
  assign use_rs1 = !(opc_d == OP_LUI || opc_d == OP_AUIPC || opc_d == OP_JAL);
  assign use_rs2 = opc_d == OP_OP || opc_d == OP_STORE || opc_d == OP_BRANCH;
  assign bad_idx = (use_rd && {1'b0, rd_d} >= NR) || (use_rs1 && {1'b0, rs1_d} >= NR) ||
                   (use_rs2 && {1'b0, rs2_d} >= NR);
  assign wr_ok = reg_file_wr_en && reg_file_wr_addr != 5'd0 && {1'b0, reg_file_wr_addr} < NR;
  assign rf1 = regs_q[rs1_d[AW-1:0]];
  assign rf2 = regs_q[rs2_d[AW-1:0]];
`ifdef DECODE_BYPASS_EN
  assign op1_d = wr_ok && reg_file_wr_addr == rs1_d ? reg_file_wr_data : rf1;
  assign op2_d = wr_ok && reg_file_wr_addr == rs2_d ? reg_file_wr_data : rf2;
`else
  assign op1_d = rf1;
  assign op2_d = rf2;
`endif
  // Only a load still sitting in ID/EX can stall; anything older is forwarded by execute.
  assign hazard   = out_valid && wb_load && rd != 5'd0 &&
                    ((use_rs1 && rd == rs1_d) || (use_rs2 && rd == rs2_d));
  assign advance  = !out_valid || ex_ready;
  assign in_ready = !rst && (id_flush || (advance && !hazard));
  assign capture  = in_valid && advance && !hazard && !id_flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      out_valid      <= 1'b0;
      pc_out         <= '0;
      op1            <= '0;
      op2            <= '0;
      immediate      <= '0;
      rs1            <= '0;
      rs2            <= '0;
      rd             <= '0;
      opcode         <= '0;
      func3          <= '0;
      func7          <= '0;
      alu_src        <= 1'b0;
      mem_write      <= 1'b0;
      wb_load        <= 1'b0;
      wb_reg_file    <= 1'b0;
      invalid_inst   <= 1'b0;
      m_type_inst    <= 1'b0;
      mem_load_type  <= '0;
      mem_store_type <= '0;
    end else begin
      if (wr_ok) regs_q[reg_file_wr_addr[AW-1:0]] <= reg_file_wr_data;
      if (capture) begin
        out_valid      <= 1'b1;
        pc_out         <= pc_in;
        op1            <= op1_d;
        op2            <= op2_d;
        immediate      <= imm_d;
        rs1            <= rs1_d;
        rs2            <= rs2_d;
        rd             <= rd_d;
        opcode         <= opc_d;
        func3          <= f3_d;
        func7          <= f7_d;
        alu_src        <= c_alu_src;
        mem_write      <= c_mem_write;
        wb_load        <= c_wb_load;
        wb_reg_file    <= c_wb_reg_file;
        invalid_inst   <= c_invalid || bad_idx;
        m_type_inst    <= c_m_type;
        mem_load_type  <= c_ld;
        mem_store_type <= c_st;
      end else if (advance) begin
        out_valid    <= 1'b0;
        mem_write    <= 1'b0;
        wb_load      <= 1'b0;
        wb_reg_file  <= 1'b0;
        invalid_inst <= 1'b0;
        m_type_inst  <= 1'b0;
      end
`ifdef DECODE_BYPASS_EN
      else if (wr_ok) begin
        if (reg_file_wr_addr == rs1) op1 <= reg_file_wr_data;
        if (reg_file_wr_addr == rs2) op2 <= reg_file_wr_data;
      end
`endif
    end
  end
endmodule
